regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
Parametrised register file for the single-cycle/pipelined datapath. Two combinational read ports, two clocked write ports and an optional hardwired-zero register 0. Adds two things the previous register file lacked: same-cycle write-to-read bypass, and a pending-write scoreboard so the issue stage can detect RAW and WAW hazards against long-latency ops such as loads.

Parameters:
DATA_W, 32, width of each register and bus
NUM_REGS, 32, number of registers; must be a power of two, at least 2
ADDR_W, $clog2(NUM_REGS), register address width (derived localparam, not overridable)
ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes and is never pending
BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
Clk  in  1  clock, rising edge
Rst_n  in  1  asynchronous active-low reset
RA  in  ADDR_W  read address A
RB  in  ADDR_W  read address B
BusA  out  DATA_W  read data A
BusB  out  DATA_W  read data B
RW0  in  ADDR_W  write address, port 0 (ALU writeback)
BusW0  in  DATA_W  write data, port 0
RegWr0  in  1  write enable, port 0
RW1  in  ADDR_W  write address, port 1 (long-latency writeback)
BusW1  in  DATA_W  write data, port 1
RegWr1  in  1  write enable, port 1; also clears pending
IssueRd  in  ADDR_W  destination register of a long-latency op being issued
IssueVld  in  1  issue request
IssueStall  out  1  issue refused (WAW against a pending register)
BusyA  out  1  register RA has a write in flight
BusyB  out  1  register RB has a write in flight
PendCount  out  ADDR_W+1  number of pending registers

Behaviour:
- Reset (Rst_n low, asynchronous):
  - all registers clear to 0;
  - scoreboard and PendCount clear to 0;
  - BusA/BusB therefore read 0, and BusyA/BusyB/IssueStall are 0 unless IssueStall is driven by current inputs.
  - Reset asserted mid-operation discards all in-flight state immediately.
- Reads: purely combinational, 0-cycle latency, no modelled delays.
- Writes: take effect at posedge Clk when the port's RegWr is high.
  - Both ports writing the same address in one cycle: port 1 wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Bypass (BYPASS=1): when RA matches an enabled write address in the same cycle, BusA returns that write's data, port 1 taking priority over port 0. BusB behaves the same with RB.
  - Address 0 with ZERO_REG=1 is never bypassed.
  - BYPASS=0: reads return the array contents, so the new value is visible the cycle after the write.
- Scoreboard: one Pend bit per register.
  - Accepted issue: IssueVld=1 and IssueStall=0, and IssueRd is not 0 when ZERO_REG=1. It sets Pend[IssueRd] at the next edge.
  - IssueStall = IssueVld and Pend[IssueRd]. This is combinational, and a stalled issue changes no state.
  - RegWr1=1 clears Pend[RW1] at the edge. Port 0 never touches the scoreboard.
  - Set and clear of the same register in the same cycle: not reachable via an accepted issue, because IssueStall refuses it. If forced, set wins.
- BusyA = Pend[RA], except with BYPASS=1 it is 0 when RegWr1=1 and RW1=RA in that cycle, because the data is being forwarded. BusyB behaves the same with RB.
- PendCount is a registered counter, not a popcount:
  - +1 on an accepted issue;
  - -1 on a port-1 write to a pending register;
  - both in the same cycle: unchanged.
  - It never exceeds NUM_REGS (NUM_REGS-1 when ZERO_REG=1) and never underflows. A port-1 write to a non-pending register does not decrement.

Decomposition:
- Shared package regfile_pkg holds the default DATA_W and NUM_REGS and the ZERO_ADDR constant.
- One sub-module, rf_scoreboard, owns the Pend bits, IssueStall, the Busy logic and PendCount.
- The storage array and the bypass muxes stay in the top level.

Test Plan:
- Reset, then write 0xDEADBEEF to r5 via port 0 and read RA=5 the next cycle -> BusA=0xDEADBEEF. Write 0x1 to r0 -> BusA at RA=0 stays 0.
- Same-cycle write and read: RegWr0 writes r7=0x11 while RA=7 -> BusA=0x11 in that cycle with BYPASS=1; with BYPASS=0, BusA shows the old value, then 0x11 the next cycle.
- Dual write collision: both ports write r3, port 0 with 0xAAAA and port 1 with 0x5555 -> r3=0x5555. Same collision on r0 -> r0 stays 0.
- Scoreboard flow:
  - issue r9 -> next cycle BusyA=1 with RA=9 and PendCount=1;
  - re-issue r9 -> IssueStall=1 and PendCount stays 1;
  - port-1 write r9=0x42 with RA=9 -> BusyA=0 and BusA=0x42 in that cycle, then PendCount=0.
- Simultaneous issue of r4 and port-1 completion of pending r2 -> PendCount unchanged, Pend[4]=1, Pend[2]=0.
- Async reset mid-operation: with r1=0x99 and r4 pending, pulse Rst_n low between clock edges -> BusA at RA=1 reads 0 immediately, PendCount=0 and BusyA=0 at RA=4.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared defaults for the multi-port register file with scoreboard.
package regfile_pkg;
  localparam int DATA_W_DEF   = 32;
  localparam int NUM_REGS_DEF = 32;
  // Address of the hardwired-zero register when ZERO_REG=1
  localparam int ZERO_ADDR    = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one Pend bit per register, issue stall on WAW,
// busy flags for the read ports and a registered pending counter.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [ADDR_W-1:0] RW1,
  input  logic              RegWr1,
  input  logic [ADDR_W-1:0] IssueRd,
  input  logic              IssueVld,
  output logic              IssueStall,
  output logic              BusyA,
  output logic              BusyB,
  output logic [ADDR_W:0]   PendCount
);

  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic                accept, clr, dec, fwd_a, fwd_b;

  // Issue acceptance, completion and the busy flags are all combinational
  always_comb begin
    IssueStall = IssueVld && pend_q[IssueRd];
    accept     = IssueVld && !IssueStall && !((ZERO_REG != 0) && (IssueRd == ZA));
    clr        = RegWr1;
    // Only a completion against a pending register reduces the count
    dec        = RegWr1 && pend_q[RW1];
    fwd_a      = (BYPASS != 0) && RegWr1 && (RW1 == RA);
    fwd_b      = (BYPASS != 0) && RegWr1 && (RW1 == RB);
    BusyA      = pend_q[RA] && !fwd_a;
    BusyB      = pend_q[RB] && !fwd_b;
  end

  // Next-state of Pend bits and counter; set is applied last so it wins
  always_comb begin
    pend_d = pend_q;
    cnt_d  = cnt_q;
    if (clr)    pend_d[RW1]     = 1'b0;
    if (accept) pend_d[IssueRd] = 1'b1;
    if (accept && !dec)      cnt_d = cnt_q + 1'b1;
    else if (dec && !accept) cnt_d = cnt_q - 1'b1;
  end

  // Scoreboard state, discarded on asynchronous reset
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign PendCount = cnt_q;

endmodule

// File: rtl/regfile_mp_sb.sv
// Two-read / two-write register file with same-cycle bypass and a
// pending-write scoreboard for long-latency writebacks.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int ADDR_W  = $clog2(NUM_REGS)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  output logic [DATA_W-1:0] BusA,
  output logic [DATA_W-1:0] BusB,
  input  logic [ADDR_W-1:0] RW0,
  input  logic [DATA_W-1:0] BusW0,
  input  logic              RegWr0,
  input  logic [ADDR_W-1:0] RW1,
  input  logic [DATA_W-1:0] BusW1,
  input  logic              RegWr1,
  input  logic [ADDR_W-1:0] IssueRd,
  input  logic              IssueVld,
  output logic              IssueStall,
  output logic              BusyA,
  output logic              BusyB,
  output logic [ADDR_W:0]   PendCount
);

  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_ADDR);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              we0, we1;

  // Writes to the hardwired-zero register are dropped at the enable
  assign we0 = RegWr0 && !((ZERO_REG != 0) && (RW0 == ZA));
  assign we1 = RegWr1 && !((ZERO_REG != 0) && (RW1 == ZA));

  // Read mux: zero register, then port 1 bypass, port 0 bypass, array
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] a);
    if ((ZERO_REG != 0) && (a == ZA))      rd = '0;
    else if ((BYPASS != 0) && we1 && (RW1 == a)) rd = BusW1;
    else if ((BYPASS != 0) && we0 && (RW0 == a)) rd = BusW0;
    else                                   rd = mem_q[a];
  endfunction

  // Combinational read ports
  always_comb begin
    BusA = rd(RA);
    BusB = rd(RB);
  end

  // Array next-state; port 1 applied after port 0 so it wins a collision
  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[RW0] = BusW0;
    if (we1) mem_d[RW1] = BusW1;
  end

  // Storage array with asynchronous clear
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) u_sb (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .RA         (RA),
    .RB         (RB),
    .RW1        (RW1),
    .RegWr1     (RegWr1),
    .IssueRd    (IssueRd),
    .IssueVld   (IssueVld),
    .IssueStall (IssueStall),
    .BusyA      (BusyA),
    .BusyB      (BusyB),
    .PendCount  (PendCount)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a bypassing instance and a
// non-bypassing instance share all inputs.
module tb_regfile_mp_sb;
  localparam int DW = 32;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Rst_n;
  logic [AW-1:0] RA, RB, RW0, RW1, IssueRd;
  logic [DW-1:0] BusW0, BusW1;
  logic          RegWr0, RegWr1, IssueVld;

  logic [DW-1:0] BusA, BusB, BusA_n, BusB_n;
  logic          IssueStall, BusyA, BusyB, IssueStall_n, BusyA_n, BusyB_n;
  logic [AW:0]   PendCount, PendCount_n;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .BusA(BusA), .BusB(BusB),
    .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0), .RW1(RW1), .BusW1(BusW1),
    .RegWr1(RegWr1), .IssueRd(IssueRd), .IssueVld(IssueVld),
    .IssueStall(IssueStall), .BusyA(BusyA), .BusyB(BusyB), .PendCount(PendCount));

  regfile_mp_sb #(.DATA_W(DW), .NUM_REGS(32), .ZERO_REG(1), .BYPASS(0)) dut_nb (
    .Clk(Clk), .Rst_n(Rst_n), .RA(RA), .RB(RB), .BusA(BusA_n), .BusB(BusB_n),
    .RW0(RW0), .BusW0(BusW0), .RegWr0(RegWr0), .RW1(RW1), .BusW1(BusW1),
    .RegWr1(RegWr1), .IssueRd(IssueRd), .IssueVld(IssueVld),
    .IssueStall(IssueStall_n), .BusyA(BusyA_n), .BusyB(BusyB_n), .PendCount(PendCount_n));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    RegWr0 = 0; RegWr1 = 0; IssueVld = 0;
  endtask

  task automatic test_reset();
    Rst_n = 0; idle(); RA = 0; RB = 0; RW0 = 0; RW1 = 0; IssueRd = 0;
    BusW0 = '0; BusW1 = '0;
    step(); step();
    RA = 5'd5; RB = 5'd9; #1;
    total++; if (BusA !== 32'h0) begin bad++; $display("FAIL reset_busa got=%h exp=0", BusA); end
    total++; if (PendCount !== 6'd0) begin bad++; $display("FAIL reset_pend got=%0d exp=0", PendCount); end
    total++; if ({BusyA, BusyB, IssueStall} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {BusyA, BusyB, IssueStall}); end
    #3 Rst_n = 1;
    step();
  endtask

  task automatic test_write_read();
    RW0 = 5'd5; BusW0 = 32'hDEADBEEF; RegWr0 = 1;
    step();
    idle(); RA = 5'd5; #1;
    total++; if (BusA !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_r5 got=%h exp=deadbeef", BusA); end
    total++; if (BusA_n !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_r5_nb got=%h exp=deadbeef", BusA_n); end
    RW0 = 5'd0; BusW0 = 32'h1; RegWr0 = 1; RA = 5'd0; #1;
    total++; if (BusA !== 32'h0) begin bad++; $display("FAIL r0_nobypass got=%h exp=0", BusA); end
    step();
    idle(); #1;
    total++; if (BusA !== 32'h0) begin bad++; $display("FAIL r0_write got=%h exp=0", BusA); end
  endtask

  task automatic test_bypass();
    RW0 = 5'd7; BusW0 = 32'h11; RegWr0 = 1; RA = 5'd7; #1;
    total++; if (BusA !== 32'h11) begin bad++; $display("FAIL byp_same got=%h exp=11", BusA); end
    total++; if (BusA_n !== 32'h0) begin bad++; $display("FAIL nobyp_old got=%h exp=0", BusA_n); end
    step();
    idle(); #1;
    total++; if (BusA_n !== 32'h11) begin bad++; $display("FAIL nobyp_next got=%h exp=11", BusA_n); end
  endtask

  task automatic test_collision();
    RW0 = 5'd3; BusW0 = 32'hAAAA; RegWr0 = 1;
    RW1 = 5'd3; BusW1 = 32'h5555; RegWr1 = 1; RB = 5'd3; #1;
    total++; if (BusB !== 32'h5555) begin bad++; $display("FAIL coll_byp got=%h exp=5555", BusB); end
    step();
    idle(); #1;
    total++; if (BusB_n !== 32'h5555) begin bad++; $display("FAIL coll_r3 got=%h exp=5555", BusB_n); end
    RW0 = 5'd0; RW1 = 5'd0; RegWr0 = 1; RegWr1 = 1; RB = 5'd0;
    step();
    idle(); #1;
    total++; if (BusB !== 32'h0 || BusB_n !== 32'h0) begin bad++; $display("FAIL coll_r0 got=%h/%h exp=0", BusB, BusB_n); end
  endtask

  task automatic test_scoreboard();
    IssueRd = 5'd9; IssueVld = 1; #1;
    total++; if (IssueStall !== 1'b0) begin bad++; $display("FAIL iss_first got=%b exp=0", IssueStall); end
    step();
    idle(); RA = 5'd9; #1;
    total++; if (BusyA !== 1'b1 || PendCount !== 6'd1) begin bad++; $display("FAIL iss_busy got=%b/%0d exp=1/1", BusyA, PendCount); end
    IssueVld = 1; #1;
    total++; if (IssueStall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%b exp=1", IssueStall); end
    step();
    idle(); #1;
    total++; if (PendCount !== 6'd1) begin bad++; $display("FAIL waw_count got=%0d exp=1", PendCount); end
    RW1 = 5'd9; BusW1 = 32'h42; RegWr1 = 1; #1;
    total++; if (BusyA !== 1'b0 || BusA !== 32'h42) begin bad++; $display("FAIL cpl_fwd got=%b/%h exp=0/42", BusyA, BusA); end
    total++; if (BusyA_n !== 1'b1) begin bad++; $display("FAIL cpl_nb_busy got=%b exp=1", BusyA_n); end
    step();
    idle(); #1;
    total++; if (PendCount !== 6'd0 || BusyA !== 1'b0) begin bad++; $display("FAIL cpl_clear got=%0d/%b exp=0/0", PendCount, BusyA); end
    // port-1 write to a non-pending register must not decrement
    RW1 = 5'd12; RegWr1 = 1;
    step();
    idle(); #1;
    total++; if (PendCount !== 6'd0) begin bad++; $display("FAIL no_underflow got=%0d exp=0", PendCount); end
  endtask

  task automatic test_back_to_back();
    IssueRd = 5'd2; IssueVld = 1;
    step();
    idle(); IssueRd = 5'd4; IssueVld = 1; RW1 = 5'd2; BusW1 = 32'h7; RegWr1 = 1;
    step();
    idle(); RA = 5'd4; RB = 5'd2; #1;
    total++; if (PendCount !== 6'd1) begin bad++; $display("FAIL b2b_count got=%0d exp=1", PendCount); end
    total++; if ({BusyA, BusyB} !== 2'b10) begin bad++; $display("FAIL b2b_pend got=%b exp=10", {BusyA, BusyB}); end
    // issue to the zero register is never accepted
    IssueRd = 5'd0; IssueVld = 1;
    step();
    idle(); RA = 5'd0; #1;
    total++; if (PendCount !== 6'd1 || BusyA !== 1'b0) begin bad++; $display("FAIL iss_r0 got=%0d/%b exp=1/0", PendCount, BusyA); end
  endtask

  task automatic test_async_reset();
    RW0 = 5'd1; BusW0 = 32'h99; RegWr0 = 1;
    step();
    idle(); RA = 5'd1; RB = 5'd4; #1;
    total++; if (BusA !== 32'h99 || BusyB !== 1'b1) begin bad++; $display("FAIL pre_rst got=%h/%b exp=99/1", BusA, BusyB); end
    #2 Rst_n = 0; #1;
    total++; if (BusA !== 32'h0) begin bad++; $display("FAIL rst_busa got=%h exp=0", BusA); end
    total++; if (PendCount !== 6'd0 || BusyB !== 1'b0) begin bad++; $display("FAIL rst_sb got=%0d/%b exp=0/0", PendCount, BusyB); end
    RA = 5'd4; #1;
    total++; if (BusyA !== 1'b0) begin bad++; $display("FAIL rst_busya got=%b exp=0", BusyA); end
    #1 Rst_n = 1;
    step();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_bypass();
    test_collision();
    test_scoreboard();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
